// File: rtl/posit_min_reduce_if.sv
// Handshake bundle for posit_min_reduce.
//   Input stream : inData, inValid, inLast  -> ; inReady <-
//   Result stream: outData, outIdx, outCount, outOverflow, outValid -> ; outReady <-
// master: the surrounding system (drives input stream, accepts results).
// slave : the reduction block.
interface posit_min_reduce_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
);
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inLast;
  logic             inReady;
  logic [WIDTH-1:0] outData;
  logic [IDX_W-1:0] outIdx;
  logic [IDX_W:0]   outCount;
  logic             outOverflow;
  logic             outValid;
  logic             outReady;

  modport master (
    output inData, inValid, inLast, outReady,
    input  inReady, outData, outIdx, outCount, outOverflow, outValid
  );

  modport slave (
    input  inData, inValid, inLast, outReady,
    output inReady, outData, outIdx, outCount, outOverflow, outValid
  );
endinterface

// File: rtl/posit_min_reduce.sv
// Streaming min/argmin (or max/argmax) reduction over vectors of packed posits.
// One element per input beat; inLast closes a vector. One cycle after the last
// beat the winning element, its zero-based index, the element count and an
// overflow flag are presented on the result handshake.
// Ports:
//   clock  - system clock
//   resetN - asynchronous active-low reset
//   bus    - posit_min_reduce_if.slave (input stream + result stream)
module posit_min_reduce #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ES     = 1,
  parameter int unsigned IS_MAX = 0,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  posit_min_reduce_if.slave     bus
);

  // Packed posit ordering is ES-independent, but a field wider than the word is meaningless.
  if (ES >= WIDTH) begin : gBadEs
    $error("posit_min_reduce: ES must be smaller than WIDTH");
  end

  // Count saturates at 2^IDX_W.
  localparam logic [IDX_W:0] FULL_CNT = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic {FIRST, ACCUM} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] acc, accNext;
  logic [IDX_W-1:0] accIdx, accIdxNext;
  logic [IDX_W:0]   cnt, cntNext;
  logic             ovf, ovfNext;

  logic beat, fire, load, isFull, xWins;

  // Packed posits order like two's-complement integers; NaR is the most negative code.
  function automatic logic positLt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

  assign bus.inReady = !bus.outValid || bus.outReady;
  assign beat        = bus.inValid && bus.inReady;
  assign fire        = bus.outValid && bus.outReady;
  assign load        = beat && bus.inLast;

  always_comb begin
    stateNext  = state;
    accNext    = acc;
    accIdxNext = accIdx;
    cntNext    = cnt;
    ovfNext    = ovf;
    isFull     = (cnt == FULL_CNT);
    xWins      = (IS_MAX != 0) ? positLt(acc, bus.inData) : positLt(bus.inData, acc);
    if (beat) begin
      unique case (state)
        FIRST: begin
          accNext    = bus.inData;
          accIdxNext = '0;
          cntNext    = (IDX_W+1)'(1);
          ovfNext    = 1'b0;
          stateNext  = bus.inLast ? FIRST : ACCUM;
        end
        ACCUM: begin
          // Strict compare keeps the earlier element on ties; once saturated
          // nothing may replace the accumulator since its index is unrepresentable.
          if (xWins && !isFull) begin
            accNext    = bus.inData;
            accIdxNext = cnt[IDX_W-1:0];
          end
          cntNext   = isFull ? cnt : cnt + (IDX_W+1)'(1);
          ovfNext   = ovf || isFull;
          stateNext = bus.inLast ? FIRST : ACCUM;
        end
        default: stateNext = FIRST;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= FIRST;
      acc    <= '0;
      accIdx <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= stateNext;
      acc    <= accNext;
      accIdx <= accIdxNext;
      cnt    <= cntNext;
      ovf    <= ovfNext;
    end
  end

  // Result register: a last beat reloads it even while the previous result fires,
  // giving back-to-back results at full throughput.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bus.outValid    <= 1'b0;
      bus.outData     <= '0;
      bus.outIdx      <= '0;
      bus.outCount    <= '0;
      bus.outOverflow <= 1'b0;
    end else if (load) begin
      bus.outValid    <= 1'b1;
      bus.outData     <= accNext;
      bus.outIdx      <= accIdxNext;
      bus.outCount    <= cntNext;
      bus.outOverflow <= ovfNext;
    end else if (fire) begin
      bus.outValid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_min_reduce.sv
module tb_posit_min_reduce;
  logic clk = 1'b0;
  logic rstAB = 1'b0;
  logic rstC = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  posit_min_reduce_if #(.WIDTH(8), .IDX_W(8)) ifA ();
  posit_min_reduce_if #(.WIDTH(8), .IDX_W(8)) ifB ();
  posit_min_reduce_if #(.WIDTH(8), .IDX_W(2)) ifC ();

  posit_min_reduce #(.WIDTH(8), .ES(1), .IS_MAX(0), .IDX_W(8)) dutA (
    .clock(clk), .resetN(rstAB), .bus(ifA.slave));
  posit_min_reduce #(.WIDTH(8), .ES(1), .IS_MAX(1), .IDX_W(8)) dutB (
    .clock(clk), .resetN(rstAB), .bus(ifB.slave));
  posit_min_reduce #(.WIDTH(8), .ES(1), .IS_MAX(0), .IDX_W(2)) dutC (
    .clock(clk), .resetN(rstC), .bus(ifC.slave));

  task automatic beatA(input logic [7:0] d, input logic last);
    ifA.inData = d; ifA.inValid = 1'b1; ifA.inLast = last;
    @(posedge clk); #1;
    ifA.inValid = 1'b0; ifA.inLast = 1'b0;
  endtask

  task automatic beatC(input logic [7:0] d, input logic last);
    ifC.inData = d; ifC.inValid = 1'b1; ifC.inLast = last;
    @(posedge clk); #1;
    ifC.inValid = 1'b0; ifC.inLast = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ifA.outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %b want 0", ifA.outValid); end
    checks++; if (ifA.inReady !== 1'b1) begin errors++; $display("FAIL rst_inReady got %b want 1", ifA.inReady); end
    checks++; if (ifA.outData !== 8'h00) begin errors++; $display("FAIL rst_outData got %h want 00", ifA.outData); end
    checks++; if (ifA.outIdx !== 8'd0) begin errors++; $display("FAIL rst_outIdx got %0d want 0", ifA.outIdx); end
    checks++; if (ifA.outCount !== 9'd0) begin errors++; $display("FAIL rst_outCount got %0d want 0", ifA.outCount); end
    checks++; if (ifA.outOverflow !== 1'b0) begin errors++; $display("FAIL rst_outOverflow got %b want 0", ifA.outOverflow); end
    @(negedge clk); rstAB = 1'b1; rstC = 1'b1;
    @(posedge clk); #1;
  endtask

  // Same 4-element vector into the min (A) and max (B) instances.
  task automatic test_min_max;
    logic [7:0] vec [4];
    vec[0] = 8'h50; vec[1] = 8'hC0; vec[2] = 8'h30; vec[3] = 8'hC0;
    ifA.outReady = 1'b1; ifB.outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifA.inData = vec[i]; ifA.inValid = 1'b1; ifA.inLast = (i == 3);
      ifB.inData = vec[i]; ifB.inValid = 1'b1; ifB.inLast = (i == 3);
      @(posedge clk); #1;
    end
    ifA.inValid = 1'b0; ifA.inLast = 1'b0; ifB.inValid = 1'b0; ifB.inLast = 1'b0;
    checks++; if (ifA.outValid !== 1'b1) begin errors++; $display("FAIL min_valid got %b want 1", ifA.outValid); end
    checks++; if (ifA.outData !== 8'hC0) begin errors++; $display("FAIL min_data got %h want c0", ifA.outData); end
    checks++; if (ifA.outIdx !== 8'd1) begin errors++; $display("FAIL min_idx got %0d want 1", ifA.outIdx); end
    checks++; if (ifA.outCount !== 9'd4) begin errors++; $display("FAIL min_count got %0d want 4", ifA.outCount); end
    checks++; if (ifA.outOverflow !== 1'b0) begin errors++; $display("FAIL min_ovf got %b want 0", ifA.outOverflow); end
    checks++; if (ifB.outData !== 8'h50) begin errors++; $display("FAIL max_data got %h want 50", ifB.outData); end
    checks++; if (ifB.outIdx !== 8'd0) begin errors++; $display("FAIL max_idx got %0d want 0", ifB.outIdx); end
    checks++; if (ifB.outCount !== 9'd4) begin errors++; $display("FAIL max_count got %0d want 4", ifB.outCount); end
    @(posedge clk); #1;
    checks++; if (ifA.outValid !== 1'b0) begin errors++; $display("FAIL min_drop got %b want 0", ifA.outValid); end
  endtask

  task automatic test_single;
    beatA(8'h40, 1'b1);
    checks++; if (ifA.outValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ifA.outValid); end
    checks++; if (ifA.outData !== 8'h40) begin errors++; $display("FAIL single_data got %h want 40", ifA.outData); end
    checks++; if (ifA.outIdx !== 8'd0) begin errors++; $display("FAIL single_idx got %0d want 0", ifA.outIdx); end
    checks++; if (ifA.outCount !== 9'd1) begin errors++; $display("FAIL single_count got %0d want 1", ifA.outCount); end
    @(posedge clk); #1;
  endtask

  // {1.0, 0.5} then {-2.0} with inValid continuous.
  task automatic test_back_to_back;
    logic [7:0] vec [3];
    logic       lst [3];
    vec[0] = 8'h40; vec[1] = 8'h30; vec[2] = 8'hB0;
    lst[0] = 1'b0;  lst[1] = 1'b1;  lst[2] = 1'b1;
    ifA.outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifA.inData = vec[i]; ifA.inValid = 1'b1; ifA.inLast = lst[i];
      #1;
      checks++; if (ifA.inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady beat %0d got %b want 1", i, ifA.inReady); end
      @(posedge clk); #1;
      if (i == 1) begin
        checks++; if (ifA.outValid !== 1'b1 || ifA.outData !== 8'h30 || ifA.outIdx !== 8'd1 || ifA.outCount !== 9'd2) begin
          errors++; $display("FAIL b2b_res1 got v%b %h i%0d c%0d want v1 30 i1 c2", ifA.outValid, ifA.outData, ifA.outIdx, ifA.outCount);
        end
      end
      if (i == 2) begin
        checks++; if (ifA.outValid !== 1'b1 || ifA.outData !== 8'hB0 || ifA.outIdx !== 8'd0 || ifA.outCount !== 9'd1) begin
          errors++; $display("FAIL b2b_res2 got v%b %h i%0d c%0d want v1 b0 i0 c1", ifA.outValid, ifA.outData, ifA.outIdx, ifA.outCount);
        end
      end
    end
    ifA.inValid = 1'b0; ifA.inLast = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    ifA.outReady = 1'b0;
    beatA(8'h50, 1'b1);
    // Offer another last beat that must not be taken while stalled.
    ifA.inData = 8'h20; ifA.inValid = 1'b1; ifA.inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ifA.inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady cyc %0d got %b want 0", i, ifA.inReady); end
      checks++; if (ifA.outValid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", i, ifA.outValid); end
      checks++; if (ifA.outData !== 8'h50 || ifA.outIdx !== 8'd0 || ifA.outCount !== 9'd1) begin
        errors++; $display("FAIL bp_stable cyc %0d got %h i%0d c%0d want 50 i0 c1", i, ifA.outData, ifA.outIdx, ifA.outCount);
      end
      @(posedge clk); #1;
    end
    ifA.inValid = 1'b0; ifA.inLast = 1'b0;
    ifA.outReady = 1'b1;
    #1;
    checks++; if (ifA.inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inReady got %b want 1", ifA.inReady); end
    @(posedge clk); #1;
    checks++; if (ifA.outValid !== 1'b0) begin errors++; $display("FAIL bp_fire got %b want 0", ifA.outValid); end
    @(posedge clk); #1;
    checks++; if (ifA.outValid !== 1'b0 || ifA.outData !== 8'h50) begin
      errors++; $display("FAIL bp_single_fire got v%b %h want v0 50", ifA.outValid, ifA.outData);
    end
  endtask

  task automatic test_overflow_reset;
    ifC.outReady = 1'b1;
    beatC(8'h40, 1'b0);
    beatC(8'h40, 1'b0);
    beatC(8'h40, 1'b0);
    beatC(8'h40, 1'b0);
    beatC(8'hC0, 1'b1);
    checks++; if (ifC.outValid !== 1'b1 || ifC.outOverflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got v%b o%b want v1 o1", ifC.outValid, ifC.outOverflow);
    end
    checks++; if (ifC.outCount !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", ifC.outCount); end
    checks++; if (ifC.outData !== 8'h40 || ifC.outIdx !== 2'd0) begin
      errors++; $display("FAIL ovf_result got %h i%0d want 40 i0", ifC.outData, ifC.outIdx);
    end
    // Hold the result, then reset between clock edges.
    ifC.outReady = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifC.outValid !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", ifC.outValid); end
    #1 rstC = 1'b0;
    #1;
    checks++; if (ifC.outValid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", ifC.outValid); end
    checks++; if (ifC.outCount !== 3'd0 || ifC.outOverflow !== 1'b0 || ifC.inReady !== 1'b1) begin
      errors++; $display("FAIL async_rst_fields got c%0d o%b r%b want c0 o0 r1", ifC.outCount, ifC.outOverflow, ifC.inReady);
    end
    #1 rstC = 1'b1;
    ifC.outReady = 1'b1;
    @(posedge clk); #1;
    // Partial vector, then reset mid-vector.
    beatC(8'h20, 1'b0);
    beatC(8'h10, 1'b0);
    #1 rstC = 1'b0;
    #1;
    checks++; if (ifC.outValid !== 1'b0) begin errors++; $display("FAIL midvec_rst_valid got %b want 0", ifC.outValid); end
    #1 rstC = 1'b1;
    @(posedge clk); #1;
    beatC(8'h60, 1'b0);
    beatC(8'h50, 1'b1);
    checks++; if (ifC.outValid !== 1'b1 || ifC.outData !== 8'h50 || ifC.outIdx !== 2'd1 || ifC.outCount !== 3'd2 || ifC.outOverflow !== 1'b0) begin
      errors++; $display("FAIL post_rst_result got v%b %h i%0d c%0d o%b want v1 50 i1 c2 o0",
                         ifC.outValid, ifC.outData, ifC.outIdx, ifC.outCount, ifC.outOverflow);
    end
  endtask

  initial begin
    ifA.inData = '0; ifA.inValid = 1'b0; ifA.inLast = 1'b0; ifA.outReady = 1'b0;
    ifB.inData = '0; ifB.inValid = 1'b0; ifB.inLast = 1'b0; ifB.outReady = 1'b0;
    ifC.inData = '0; ifC.inValid = 1'b0; ifC.inLast = 1'b0; ifC.outReady = 1'b0;
    test_reset();
    test_min_max();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/posit_min_reduce.md
Name: posit_min_reduce

Overview:
Streaming min/argmin reduction over vectors of packed posits. Accepts one PositPacked element per beat on a valid/ready input stream, with a last flag marking the end of each vector. After the last element is accepted, it presents the vector minimum (or maximum, per IS_MAX), the index of that element and the element count on a valid/ready output.
Sits downstream of the posit encode/pack stage. Used for softmax max-subtraction and pooling layers.

Parameters:
WIDTH, 8, posit total bit width
ES, 1, posit exponent field width
IS_MAX, 0, 0 = reduce to minimum, 1 = reduce to maximum
IDX_W, 8, index/count width; supported vector length is 1..2^IDX_W

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
in  PositPacked.InputIf  P  input element data (P = PositPacked(WIDTH,ES) data width)
inValid  in  1  input element valid
inLast  in  1  input element is the last of its vector
inReady  out  1  block can accept an input element
out  PositPacked.OutputIf  P  reduced result data
outIdx  out  IDX_W  zero-based index of the selected element
outCount  out  IDX_W+1  number of elements in the vector
outOverflow  out  1  vector was longer than 2^IDX_W
outValid  out  1  result valid
outReady  in  1  downstream accepts the result

Behaviour:
- One clock (clock); reset is asynchronous and active-low (resetN). Reset state applies immediately on resetN low, regardless of clock.
- Reset values:
  - outValid=0, inReady=1.
  - out.data=0, outIdx=0, outCount=0, outOverflow=0.
  - Internal state: state=FIRST, acc=0, accIdx=0, cnt=0, ovf=0.
- Handshakes:
  - Input beat fires when inValid&inReady.
  - Output fires when outValid&outReady.
  - inReady = !outValid | outReady (combinational). There is no combinational path from in to out.
  - outValid, once set, holds until it fires; the out fields are stable while held.
- Ordering:
  - Use PositComparePacked(WIDTH,ES) with comp=LT.
  - IS_MAX=0: a new element x replaces acc iff x<acc.
  - IS_MAX=1: a new element x replaces acc iff acc<x.
  - Ties keep the earlier element (lowest index).
  - NaR/zero ordering is exactly that of PositComparePacked.
- States:
  - FIRST: on a beat, acc<=x, accIdx<=0, cnt<=1, ovf<=0. If inLast, go to a result load (below) using x, idx 0, count 1; else go to ACCUM.
  - ACCUM: on a beat, compare x against acc and update acc/accIdx<=cnt[IDX_W-1:0] if x wins; cnt<=cnt+1.
    - If cnt==2^IDX_W before the increment: cnt saturates at 2^IDX_W, ovf<=1, and further elements are still compared but never replace acc.
    - On inLast: load the result, go to FIRST.
- Result load (single-cycle latency from the last beat):
  - out.data/outIdx <= the winner of acc vs x.
  - outCount <= updated cnt; outOverflow <= updated ovf; outValid<=1.
- Simultaneous events:
  - Output fire with no new result: outValid<=0.
  - Output fire in the same cycle as a last beat: outValid stays 1 with the new result (back-to-back, full throughput).
  - Output fire in the same cycle as a non-last beat: accumulation proceeds normally.
- Single-element vector: inLast on a FIRST beat yields outIdx=0, outCount=1, out.data=x.
- Backpressure: while outValid=1 and outReady=0, inReady=0 and the accumulator is frozen.
- Reset mid-vector: the partial vector is discarded, the next beat is treated as FIRST, and outValid drops immediately.

Test Plan:
- Min over 4-element vector, posit8 ES=1, values {2.0 (0x50), -1.0 (0xC0), 0.5 (0x30), -1.0 (0xC0)}, last on the 4th element, outReady=1 -> one cycle after the last beat: outValid=1, out=-1.0, outIdx=1 (tie keeps earlier), outCount=4, outOverflow=0.
- IS_MAX=1 with the same vector -> out=2.0, outIdx=0, outCount=4.
- Single element 0x40 (1.0) with inLast -> next cycle: out=1.0, outIdx=0, outCount=1.
- Back-to-back vectors {1.0, 0.5} then {-2.0}, outReady=1 throughout, inValid continuous -> inReady never drops; results are (0.5, idx1, cnt2) then (-2.0, idx0, cnt1) on consecutive result cycles.
- Hold outReady=0 for 5 cycles after a result -> inReady=0 and out fields stable for all 5 cycles; after outReady=1, exactly one output fire occurs and inReady=1 the same cycle.
- IDX_W=2, 5-element vector {1,1,1,1,-1} -> outOverflow=1, outCount=4, out=1.0, outIdx=0. Then assert resetN low mid-vector -> outValid=0 immediately, and the next vector reduces correctly from a clean state.
